// File: rtl/switch_pkg.sv
// Shared constants for the switch input block: halfword offsets of the
// debounced-level and change-flag registers within the IO window.
package switch_pkg;

   localparam logic [2:0] SW_ADDR_DLO  = 3'b000;
   localparam logic [2:0] SW_ADDR_DHI  = 3'b010;
   localparam logic [2:0] SW_ADDR_CLO  = 3'b100;
   localparam logic [2:0] SW_ADDR_CHI  = 3'b110;
   localparam int         SW_MAX_WIDTH = 32;

endpackage

// File: rtl/sw_debounce.sv
// Vector-wide synchroniser and sample-voting debouncer. chg_set pulses on
// the same falling edge that a bit's debounced level flips.
module sw_debounce #(
   parameter int SW_WIDTH     = 24,
   parameter int SYNC_STAGES  = 2,
   parameter int DBNC_SAMPLES = 3
) (
   input  logic                switclk,
   input  logic                switrst,
   input  logic                tick,
   input  logic [SW_WIDTH-1:0] sw_raw,
   output logic [SW_WIDTH-1:0] db,
   output logic [SW_WIDTH-1:0] chg_set
);

   logic [SYNC_STAGES-1:0][SW_WIDTH-1:0]  sync_r;
   logic [DBNC_SAMPLES-1:0][SW_WIDTH-1:0] samp_r;
   logic [DBNC_SAMPLES-1:0][SW_WIDTH-1:0] samp_nxt_s;
   logic [SW_WIDTH-1:0]                   all_hi_s;
   logic [SW_WIDTH-1:0]                   all_lo_s;
   logic [SW_WIDTH-1:0]                   chg_set_s;
   logic [SW_WIDTH-1:0]                   db_r;
   logic [SW_WIDTH-1:0]                   db_nxt_s;

   // Vote on the post-shift sample window; index 0 holds the newest sample.
   always_comb begin
      samp_nxt_s = {samp_r[DBNC_SAMPLES-2:0], sync_r[SYNC_STAGES-1]};
      all_hi_s   = {SW_WIDTH{1'b1}};
      all_lo_s   = {SW_WIDTH{1'b1}};
      for (int k = 0; k < DBNC_SAMPLES; k++) begin
         all_hi_s = all_hi_s & samp_nxt_s[k];
         all_lo_s = all_lo_s & ~samp_nxt_s[k];
      end
      if (tick) begin
         chg_set_s = (all_hi_s & ~db_r) | (all_lo_s & db_r);
      end else begin
         chg_set_s = {SW_WIDTH{1'b0}};
      end
      db_nxt_s = db_r ^ chg_set_s;
   end

   // Synchroniser chain, sample window and debounced level registers.
   always_ff @(negedge switclk or posedge switrst) begin
      if (switrst) begin
         sync_r <= {(SYNC_STAGES * SW_WIDTH){1'b0}};
         samp_r <= {(DBNC_SAMPLES * SW_WIDTH){1'b0}};
         db_r   <= {SW_WIDTH{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], sw_raw};
         if (tick) begin
            samp_r <= samp_nxt_s;
         end
         db_r <= db_nxt_s;
      end
   end

   assign db      = db_r;
   assign chg_set = chg_set_s;

endmodule

// File: rtl/switch_ctrl_dbnc.sv
// Debounced switch port on the CPU IO bus: levels, clear-on-read change
// flags and a level interrupt, all clocked on the falling edge of switclk.
module switch_ctrl_dbnc
   import switch_pkg::*;
#(
   parameter int SW_WIDTH     = 24,
   parameter int SYNC_STAGES  = 2,
   parameter int DBNC_CYCLES  = 20000,
   parameter int DBNC_SAMPLES = 3
) (
   input  logic                switclk,
   input  logic                switrst,
   input  logic                switchcs,
   input  logic                switchread,
   input  logic [2:0]          switchaddr,
   input  logic [SW_WIDTH-1:0] switch_i,
   output logic [15:0]         switchrdata,
   output logic                sw_irq
);

   localparam int CNT_W = $clog2(DBNC_CYCLES);

   logic [CNT_W-1:0]        presc_r;
   logic                    tick_s;
   logic [SW_WIDTH-1:0]     db_s;
   logic [SW_WIDTH-1:0]     chg_set_s;
   logic [SW_WIDTH-1:0]     chg_r;
   logic [SW_WIDTH-1:0]     chg_nxt_s;
   logic [SW_WIDTH-1:0]     clr_s;
   logic [SW_MAX_WIDTH-1:0] db_ext_s;
   logic [SW_MAX_WIDTH-1:0] chg_ext_s;
   logic                    clr_lo_s;
   logic                    clr_hi_s;
   logic [15:0]             rdata_r;
   logic [15:0]             rdata_nxt_s;
   logic                    irq_r;

   assign tick_s = (presc_r == CNT_W'(DBNC_CYCLES - 1));

   // Free-running prescaler that paces debounce sampling.
   always_ff @(negedge switclk or posedge switrst) begin
      if (switrst) begin
         presc_r <= CNT_W'(0);
      end else if (tick_s) begin
         presc_r <= CNT_W'(0);
      end else begin
         presc_r <= presc_r + CNT_W'(1);
      end
   end

   sw_debounce #(
      .SW_WIDTH     (SW_WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .DBNC_SAMPLES (DBNC_SAMPLES)
   ) u_debounce (
      .switclk (switclk),
      .switrst (switrst),
      .tick    (tick_s),
      .sw_raw  (switch_i),
      .db      (db_s),
      .chg_set (chg_set_s)
   );

   // Read mux and clear mask; a set arriving with its clear keeps the flag.
   always_comb begin
      db_ext_s                 = {SW_MAX_WIDTH{1'b0}};
      db_ext_s[SW_WIDTH-1:0]   = db_s;
      chg_ext_s                = {SW_MAX_WIDTH{1'b0}};
      chg_ext_s[SW_WIDTH-1:0]  = chg_r;
      rdata_nxt_s              = rdata_r;
      clr_lo_s                 = 1'b0;
      clr_hi_s                 = 1'b0;
      if (switchcs && switchread) begin
         case (switchaddr)
            SW_ADDR_DLO: rdata_nxt_s = db_ext_s[15:0];
            SW_ADDR_DHI: rdata_nxt_s = db_ext_s[31:16];
            SW_ADDR_CLO: begin
               rdata_nxt_s = chg_ext_s[15:0];
               clr_lo_s    = 1'b1;
            end
            SW_ADDR_CHI: begin
               rdata_nxt_s = chg_ext_s[31:16];
               clr_hi_s    = 1'b1;
            end
            default: rdata_nxt_s = rdata_r;
         endcase
      end else begin
         rdata_nxt_s = rdata_r;
      end
      clr_s = {SW_WIDTH{1'b0}};
      for (int i = 0; i < SW_WIDTH; i++) begin
         clr_s[i] = (i < 16) ? clr_lo_s : clr_hi_s;
      end
      chg_nxt_s = (chg_r & ~clr_s) | chg_set_s;
   end

   // Change flags, read data and interrupt registers.
   always_ff @(negedge switclk or posedge switrst) begin
      if (switrst) begin
         chg_r   <= {SW_WIDTH{1'b0}};
         rdata_r <= 16'h0000;
         irq_r   <= 1'b0;
      end else begin
         chg_r   <= chg_nxt_s;
         rdata_r <= rdata_nxt_s;
         irq_r   <= |chg_nxt_s;
      end
   end

   assign switchrdata = rdata_r;
   assign sw_irq      = irq_r;

endmodule
